pps_align_ctrl: RTL and testbench

- Sequencer for the local 1PPS divider in the GPSDO.
- Measures the signed phase error between the GPS 1PPS and the local 1PPS each second.
- Issues DIV_RST pulses to force the divider to re-align when the error stays out of tolerance.
- Tracks lock state and GPS loss; its results feed the oscillator discipline loop.

---
 rtl/pps_align_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pps_align_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_align_ctrl.sv
// 1PPS alignment sequencer: measures GPS-vs-local phase each second, requests
// divider resets when out of tolerance, and tracks lock and GPS loss.
module pps_align_ctrl #(
  parameter int PERIOD      = 10_000_000,
  parameter int THRESH      = 100,
  parameter int BAD_LIMIT   = 3,
  parameter int LOCK_COUNT  = 8,
  parameter int RST_HOLD    = 4,
  parameter int GPS_TIMEOUT = 11_000_000
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic               ctrl_en,
  input  logic               _1PPS_GPS,
  input  logic               _1PPS_Local,
  output logic               DIV_RST,
  output logic signed [24:0] phase_err,
  output logic               phase_valid,
  output logic               locked,
  output logic               gps_lost,
  output logic [7:0]         resync_cnt
);

  localparam int BadW  = $clog2(BAD_LIMIT + 1);
  localparam int GoodW = $clog2(LOCK_COUNT + 1);
  localparam int HoldW = $clog2(RST_HOLD);
  localparam int WdW   = $clog2(GPS_TIMEOUT + 1);

  localparam logic [24:0]      Period25   = 25'(PERIOD);
  localparam logic [24:0]      HalfPeriod = 25'(PERIOD / 2);
  localparam logic [24:0]      Thresh25   = 25'(THRESH);
  localparam logic [23:0]      PeriodLast = 24'(PERIOD - 1);
  localparam logic [BadW-1:0]  BadMax     = BadW'(BAD_LIMIT);
  localparam logic [GoodW-1:0] GoodMax    = GoodW'(LOCK_COUNT);
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(RST_HOLD - 1);
  localparam logic [WdW-1:0]   WdMax      = WdW'(GPS_TIMEOUT);

  typedef enum logic [2:0] {IDLE, RESYNC, WAIT_GPS, MEASURE, EVAL} state_t;

  state_t            state;
  logic [2:0]        gps_sh, loc_sh;  // [0] meta, [1] synced, [2] previous
  logic              gps_edge, loc_edge;
  logic [23:0]       meas_cnt;
  logic [24:0]       meas_e;
  logic              meas_ok;
  logic [HoldW-1:0]  hold_cnt;
  logic [BadW-1:0]   bad_cnt, bad_next;
  logic [GoodW-1:0]  good_cnt, good_next;
  logic [WdW-1:0]    wd_cnt;
  logic              div_rst_q;
  logic signed [24:0] err_calc;
  logic [24:0]       err_abs;
  logic              err_good, go_resync;

  assign gps_edge = gps_sh[1] & ~gps_sh[2];
  assign loc_edge = loc_sh[1] & ~loc_sh[2];
  // Gated so that dropping ctrl_en releases the divider without waiting a cycle.
  assign DIV_RST  = div_rst_q & ctrl_en;

  // NOTE: every variable assigned in always_comb gets a value first, so no latch can be inferred.
  always_comb begin
    err_calc  = (meas_e <= HalfPeriod) ? meas_e : meas_e - Period25;
    err_abs   = err_calc[24] ? -err_calc : err_calc;
    err_good  = meas_ok && (err_abs <= Thresh25);
    bad_next  = err_good ? '0 : ((bad_cnt == BadMax) ? bad_cnt : bad_cnt + 1'b1);
    good_next = !err_good ? '0 : ((good_cnt == GoodMax) ? good_cnt : good_cnt + 1'b1);
    go_resync = (state == IDLE) || ((state == EVAL) && (bad_next == BadMax));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state       <= IDLE;
      gps_sh      <= '0;
      loc_sh      <= '0;
      meas_cnt    <= '0;
      meas_e      <= '0;
      meas_ok     <= 1'b0;
      hold_cnt    <= '0;
      bad_cnt     <= '0;
      good_cnt    <= '0;
      wd_cnt      <= '0;
      div_rst_q   <= 1'b0;
      phase_err   <= '0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      gps_lost    <= 1'b0;
      resync_cnt  <= '0;
    end else begin
      gps_sh      <= {gps_sh[1:0], _1PPS_GPS};
      loc_sh      <= {loc_sh[1:0], _1PPS_Local};
      phase_valid <= 1'b0;

      if (!ctrl_en) begin
        state     <= IDLE;
        div_rst_q <= 1'b0;
        locked    <= 1'b0;
        bad_cnt   <= '0;
        good_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          RESYNC: begin
            if (hold_cnt == HoldLast) begin
              div_rst_q <= 1'b0;
              state     <= WAIT_GPS;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          WAIT_GPS: begin
            if (gps_edge) begin
              meas_cnt <= '0;
              if (loc_edge) begin
                meas_e  <= '0;
                meas_ok <= 1'b1;
                state   <= EVAL;
              end else begin
                state <= MEASURE;
              end
            end
          end
          MEASURE: begin
            if (loc_edge) begin
              meas_e  <= {1'b0, meas_cnt} + 25'd1;
              meas_ok <= 1'b1;
              state   <= EVAL;
            end else if (meas_cnt == PeriodLast) begin
              meas_ok <= 1'b0;
              state   <= EVAL;
            end else begin
              meas_cnt <= meas_cnt + 1'b1;
            end
          end
          EVAL: begin
            if (meas_ok) begin
              phase_err   <= err_calc;
              phase_valid <= 1'b1;
            end
            bad_cnt  <= bad_next;
            good_cnt <= good_next;
            if (!err_good)                locked <= 1'b0;
            else if (good_next == GoodMax) locked <= 1'b1;
            state <= WAIT_GPS;
          end
          default: state <= IDLE;
        endcase

        // Resync entry overrides the per-state updates above.
        if (go_resync) begin
          state     <= RESYNC;
          div_rst_q <= 1'b1;
          hold_cnt  <= '0;
          locked    <= 1'b0;
          bad_cnt   <= '0;
          good_cnt  <= '0;
          if (resync_cnt != 8'hFF) resync_cnt <= resync_cnt + 1'b1;
        end
      end

      // GPS watchdog runs regardless of ctrl_en and never moves the FSM.
      if (gps_edge) begin
        wd_cnt   <= '0;
        gps_lost <= 1'b0;
      end else if (wd_cnt != WdMax) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WdMax - 1'b1) begin
          gps_lost <= 1'b1;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pps_align_ctrl.sv
// Self-checking bench for pps_align_ctrl: per-second GPS/local pulse pairs
// are scored against a second-level reference model of the alignment rules.
module tb_pps_align_ctrl;

  localparam int PERIOD      = 1000;
  localparam int THRESH      = 5;
  localparam int BAD_LIMIT   = 3;
  localparam int LOCK_COUNT  = 4;
  localparam int RST_HOLD    = 4;
  localparam int GPS_TIMEOUT = 1100;
  localparam int SEC_CYCLES  = 1050;  // bench "second": spacing between GPS pulses
  localparam int SYNC_LAT    = 3;     // input rise to edge acted upon

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctrl_en = 1'b0;
  logic gps = 1'b0;
  logic loc = 1'b0;
  logic               div_rst;
  logic signed [24:0] phase_err;
  logic               phase_valid, locked, gps_lost;
  logic [7:0]         resync_cnt;

  always #5 clk = ~clk;

  pps_align_ctrl #(
    .PERIOD(PERIOD), .THRESH(THRESH), .BAD_LIMIT(BAD_LIMIT),
    .LOCK_COUNT(LOCK_COUNT), .RST_HOLD(RST_HOLD), .GPS_TIMEOUT(GPS_TIMEOUT)
  ) dut (
    .CLK_SYS(clk), .CLK_RST(rst_n), .ctrl_en(ctrl_en),
    ._1PPS_GPS(gps), ._1PPS_Local(loc),
    .DIV_RST(div_rst), .phase_err(phase_err), .phase_valid(phase_valid),
    .locked(locked), .gps_lost(gps_lost), .resync_cnt(resync_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, advanced once per second of stimulus.
  int m_good = 0, m_bad = 0, m_resync = 0, m_err = 0;
  bit m_locked = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // d < 0 means no local edge this second; otherwise local rises d cycles after GPS.
  task automatic model_second(input int d, output bit valid, output int err, output bit resync);
    bit good;
    valid = (d >= 0);
    err   = m_err;
    if (valid) begin
      err   = (d <= PERIOD / 2) ? d : d - PERIOD;
      m_err = err;
    end
    good = valid && (err <= THRESH) && (err >= -THRESH);
    if (good) begin
      m_bad = 0;
      if (m_good < LOCK_COUNT) m_good++;
      if (m_good == LOCK_COUNT) m_locked = 1'b1;
    end else begin
      m_bad++;
      m_good   = 0;
      m_locked = 1'b0;
    end
    resync = (m_bad == BAD_LIMIT);
    if (resync) begin
      m_resync = (m_resync < 255) ? m_resync + 1 : 255;
      m_bad    = 0;
      m_good   = 0;
      m_locked = 1'b0;
    end
  endtask

  task automatic run_second(input int d, input string tag);
    bit exp_valid, exp_resync;
    int exp_err, pv, rst_cycles, got_err;
    model_second(d, exp_valid, exp_err, exp_resync);
    pv = 0; rst_cycles = 0; got_err = 0;
    for (int k = 0; k < SEC_CYCLES; k++) begin
      gps = (k < 3);
      loc = (d >= 0) && (k >= d) && (k < d + 3);
      @(posedge clk); #1;
      if (phase_valid) begin
        pv++;
        got_err = phase_err;
      end
      if (div_rst) rst_cycles++;
    end
    gps = 1'b0; loc = 1'b0;
    check({tag, ":valid_count"}, pv, exp_valid ? 1 : 0);
    if (exp_valid) check({tag, ":phase_err"}, got_err, exp_err);
    check({tag, ":locked"}, locked, m_locked);
    check({tag, ":resync_cnt"}, resync_cnt, m_resync);
    check({tag, ":div_rst_cycles"}, rst_cycles, exp_resync ? RST_HOLD : 0);
    check({tag, ":gps_lost"}, gps_lost, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, hi, d, kind;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst:div_rst", div_rst, 0);
    check("rst:phase_err", phase_err, 0);
    check("rst:phase_valid", phase_valid, 0);
    check("rst:locked", locked, 0);
    check("rst:gps_lost", gps_lost, 0);
    check("rst:resync_cnt", resync_cnt, 0);

    // Startup resync pulse
    rst_n = 1'b1; ctrl_en = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (div_rst) hi++;
    end
    m_resync++;
    check("startup:div_rst_cycles", hi, RST_HOLD);
    check("startup:resync_cnt", resync_cnt, m_resync);

    // Lagging local by 2 cycles: lock after the 4th measurement
    for (int i = 0; i < 4; i++) run_second(2, "lag2");
    // Leading local by 3 cycles
    for (int i = 0; i < 2; i++) run_second(997, "lead3");
    // Drift to +20 for three seconds forces a resync
    for (int i = 0; i < 3; i++) run_second(20, "drift20");

    // Randomized seconds: good lag, good lead, bad offset, or missing local
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       d = $urandom_range(0, THRESH);
        1:       d = $urandom_range(PERIOD - THRESH, PERIOD - 1);
        2:       d = $urandom_range(THRESH + 1, PERIOD - THRESH - 1);
        default: d = -1;
      endcase
      run_second(d, "random");
    end

    // GPS loss: last GPS pulse, then silence
    run_second(2, "pre_loss");
    n = SEC_CYCLES;
    while (!gps_lost && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    m_locked = 1'b0;
    check("gps_loss:latency", n, SYNC_LAT + GPS_TIMEOUT);
    check("gps_loss:gps_lost", gps_lost, 1);
    check("gps_loss:locked", locked, 0);
    run_second(2, "gps_restore");

    // Coincident edges, then missing local edges, then a fresh good second
    run_second(0, "coincident");
    for (int i = 0; i < 3; i++) run_second(-1, "no_local");
    run_second(3, "post_noloc");

    // ctrl_en low: back to IDLE, counters retained, phase_err held
    ctrl_en = 1'b0;
    @(posedge clk); #1;
    m_good = 0; m_bad = 0; m_locked = 1'b0;
    check("disable:locked", locked, 0);
    check("disable:resync_cnt", resync_cnt, m_resync);
    check("disable:phase_err_held", phase_err, m_err);

    // Re-enable gives a full pulse from IDLE
    ctrl_en = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (div_rst) hi++;
    end
    m_resync++;
    check("reenable:div_rst_cycles", hi, RST_HOLD);
    check("reenable:resync_cnt", resync_cnt, m_resync);

    // ctrl_en dropped mid-pulse
    ctrl_en = 1'b0;
    @(posedge clk); #1;
    ctrl_en = 1'b1;
    n = 0;
    while (!div_rst && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    m_resync++;
    check("mid_en:pulse_started", div_rst, 1);
    @(posedge clk); #1;
    ctrl_en = 1'b0;
    #1;
    check("mid_en:div_rst_drop", div_rst, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_en:resync_cnt_kept", resync_cnt, m_resync);
    check("mid_en:phase_err_held", phase_err, m_err);
    ctrl_en = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (div_rst) hi++;
    end
    m_resync++;
    check("mid_en:idle_full_pulse", hi, RST_HOLD);

    // CLK_RST asserted mid-pulse
    ctrl_en = 1'b0;
    @(posedge clk); #1;
    ctrl_en = 1'b1;
    n = 0;
    while (!div_rst && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_rst:pulse_started", div_rst, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst:div_rst", div_rst, 0);
    check("mid_rst:resync_cnt", resync_cnt, 0);
    check("mid_rst:phase_err", phase_err, 0);
    check("mid_rst:locked", locked, 0);
    check("mid_rst:phase_valid", phase_valid, 0);
    ctrl_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst:idle_after", div_rst, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
